mux5_rr_sel_ctrl: RTL and testbench
===================================

# mux5_rr_sel_ctrl

Round-robin select controller that drives the 3-bit select of the 5:1 data mux stage. It arbitrates among five request lines, registers a stable binary select plus one-hot grant, and holds them until the downstream consumer acknowledges the muxed output. It sits directly upstream of the 5:1 mux: its `sel` feeds the mux select, with `sel` = 4 choosing input 4.

## Interface
- `TIMEOUT`, default 8: number of consecutive unacknowledged grant cycles before forced release. Valid range 2..255. Used only with `MUX5_TIMEOUT_EN`.
- `clk`  input  1  clock; all logic on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `req`  input  5  request per mux input; bit k requests input k.
- `ack`  input  1  consumer has taken the muxed output this cycle.
- `sel`  output  3  binary select to the mux, 0..4; values 5..7 are never driven.
- `gnt`  output  5  one-hot grant matching `sel`; all zero when `vld`=0.
- `vld`  output  1  `sel`/`gnt` are valid and a muxed output is being offered.
- `tout`  output  1  one-cycle pulse on a forced release.

## Operation
- State is `IDLE` or `GRANT`. Internal `ptr` (3 bits, 0..4) holds the highest-priority index.
- Reset (`rst_n`=0 at an edge) sets state=`IDLE`, `ptr`=0, `sel`=0, `gnt`=0, `vld`=0, `tout`=0, and the timeout counter to 0. A reset during `GRANT` drops the grant with no `tout` pulse.
- Arbitration picks the first k with `req[k]`=1, scanning `ptr`, `ptr`+1, … mod 5. No request means no grant.
- In `IDLE`, if any `req` bit is set, register the winner into `sel` and `gnt`, set `vld`=1, and go to `GRANT`. Otherwise stay in `IDLE` with `vld`=0, and `sel` holds its last value.
- In `GRANT`, `sel` and `gnt` are frozen. Changes or deassertion of `req` are ignored until release.
- Release happens when `vld`&`ack`=1:
  - `ptr` becomes (`sel`+1) mod 5, so 4 wraps to 0.
  - If any `req` bit is set in the same cycle, re-arbitrate using the new `ptr` and present the new grant on the next cycle (back-to-back). The just-served requester has lowest priority.
  - If no `req` bit is set, `vld`=0 and `gnt`=0 next cycle, and the state returns to `IDLE`.
- `ack` while `vld`=0 is ignored.

## Timing
- Latency from a `req` edge in `IDLE` to `vld`=1 is one cycle, with registered outputs.
- On an `ack` cycle, the next grant (if any) appears on the following cycle. There is no idle bubble on back-to-back grants.
- All outputs come straight from registers, with no combinational path from `req` or `ack`.

## Configuration
- Macro: `MUX5_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to `GRANT` and increments each `GRANT` cycle without `ack`.
  - On the `TIMEOUT`-th consecutive unacknowledged `vld` cycle, that cycle is treated as a release. `ptr` advances, and re-arbitration or return to `IDLE` follows exactly as on `ack`.
  - `tout`=1 for exactly the next cycle.
  - `ack` in the same cycle as expiry counts as a normal release with no `tout`.
- Undefined:
  - No counter is built and `tout` is tied to 0.
  - A grant is held indefinitely until `ack`.

## Test plan
- Reset: hold `rst_n`=0 with `req`=5'b11111 → `vld`=0, `gnt`=0, `sel`=0, `tout`=0. Release reset → next cycle `sel`=0, `gnt`=5'b00001.
- Rotation: hold `req`=5'b11111 and `ack`=1 continuously → `sel` sequence 0,1,2,3,4,0 on consecutive cycles with `vld` constantly 1.
- Skip and wrap: `ptr`=3 (after serving input 2), `req`=5'b00101 → `sel`=0 (index 3 and 4 not requesting, wrap to 0). Next `ack` → `sel`=2.
- Hold: grant `sel`=1, then drop `req[1]` and raise `req[4]` with no `ack` for 5 cycles → `sel`=1 and `gnt`=5'b00010 stay stable. `ack` → `sel`=4 next cycle.
- Idle return: single `req`=5'b01000 with an `ack` after the grant, `req` then 0 → `vld`=0 next cycle and state stays `IDLE`. Re-raise `req[3]` → `sel`=3 after one cycle.
- Timeout (`MUX5_TIMEOUT_EN`, `TIMEOUT`=8): `req`=5'b00011 with no `ack` → grant `sel`=0 held 8 cycles, then `tout`=1 for one cycle with `sel`=1 `vld`=1 in that same cycle. Without the macro → `sel`=0 held for 20 cycles with `tout`=0.

Source files
------------

// File: rtl/mux5_rr_sel_ctrl.sv
// Round-robin select controller for a 5:1 mux: registers sel/gnt and holds them until ack.
// Optional forced release after TIMEOUT unacknowledged cycles when MUX5_TIMEOUT_EN is defined.
module mux5_rr_sel_ctrl #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req,
  input  logic       ack,
  output logic [2:0] sel,
  output logic [4:0] gnt,
  output logic       vld,
  output logic       tout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] sel_nxt;
  logic [4:0] gnt_nxt;
  logic       vld_nxt;
  logic [2:0] ptr_inc;
  logic [2:0] arb_base;
  logic [2:0] arb_win;
  logic       arb_any;
  logic       expire;
  logic       release_grant;

  // First requester found scanning base, base+1, ... modulo 5.
  function automatic logic [2:0] rr_pick(input logic [4:0] r, input logic [2:0] base);
    logic [3:0] s;
    logic [2:0] win;
    win = base;
    for (int i = 4; i >= 0; i--) begin
      s = {1'b0, base} + 4'(i);
      if (s >= 4'd5) s = s - 4'd5;
      if (r[s[2:0]]) win = s[2:0];
    end
    return win;
  endfunction

  // On release the pointer moves past the served input, so re-arbitration uses it directly.
  assign ptr_inc  = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
  assign arb_base = (state == GRANT) ? ptr_inc : ptr;
  assign arb_any  = |req;
  assign arb_win  = rr_pick(req, arb_base);

`ifdef MUX5_TIMEOUT_EN
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       tout_q;

  // ack on the expiry cycle wins: it is a normal release with no tout.
  assign expire  = (state == GRANT) && !ack && (cnt == 8'(TIMEOUT - 1));
  assign cnt_nxt = ((state == GRANT) && !ack && !expire) ? cnt + 8'd1 : 8'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 8'd0;
      tout_q <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      tout_q <= expire;
    end
  end

  assign tout = tout_q;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign expire         = 1'b0;
  assign tout           = 1'b0;
`endif

  assign release_grant = ack || expire;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    vld_nxt   = vld;
    case (state)
      IDLE: begin
        if (arb_any) begin
          sel_nxt   = arb_win;
          gnt_nxt   = 5'b00001 << arb_win;
          vld_nxt   = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_grant) begin
          ptr_nxt = ptr_inc;
          if (arb_any) begin
            sel_nxt = arb_win;
            gnt_nxt = 5'b00001 << arb_win;
            vld_nxt = 1'b1;
          end else begin
            gnt_nxt   = 5'b00000;
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        gnt_nxt   = 5'b00000;
        vld_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      sel   <= 3'd0;
      gnt   <= 5'b00000;
      vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      vld   <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_mux5_rr_sel_ctrl.sv
// Directed and randomized checks of mux5_rr_sel_ctrl against a behavioural round-robin model.
module tb_mux5_rr_sel_ctrl;

  localparam int TO = 8;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic       ack;
  logic [2:0] sel;
  logic [4:0] gnt;
  logic       vld;
  logic       tout;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_vld;
  int m_sel;
  int m_ptr;
  int m_held;
  bit m_tout;

  mux5_rr_sel_ctrl #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .ack  (ack),
    .sel  (sel),
    .gnt  (gnt),
    .vld  (vld),
    .tout (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [4:0] r, input int base);
    for (int j = 0; j < 5; j++)
      if (r[(base + j) % 5]) return (base + j) % 5;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge();
    bit expd;
    int w;
    if (!rst_n) begin
      m_vld = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_tout = 0;
      return;
    end
    m_tout = 0;
    expd   = 0;
    if (m_vld) begin
`ifdef MUX5_TIMEOUT_EN
      if (!ack) begin
        m_held++;
        if (m_held >= TO) expd = 1;
      end
`endif
      if (ack || expd) begin
        m_ptr  = (m_sel + 1) % 5;
        m_tout = expd;
        w = pick(req, m_ptr);
        if (w >= 0) begin
          m_sel = w; m_held = 0;
        end else begin
          m_vld = 0;
        end
      end
    end else begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_sel = w; m_vld = 1; m_held = 0;
      end
    end
  endtask

  // One clock with the given inputs, then compare every output with the model.
  task automatic step(input logic [4:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    model_edge();
    #1;
    check("vld",  8'(vld),  8'(m_vld));
    check("sel",  8'(sel),  8'(m_sel));
    check("gnt",  8'(gnt),  m_vld ? 8'(5'b00001 << m_sel) : 8'd0);
    check("tout", 8'(tout), 8'(m_tout));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 5'b11111;
    ack   = 1'b0;

    for (int i = 0; i < 3; i++) step(5'b11111, 1'b0);
    check("rst_vld", 8'(vld), 8'd0);
    check("rst_gnt", 8'(gnt), 8'd0);
    check("rst_sel", 8'(sel), 8'd0);
    check("rst_tout", 8'(tout), 8'd0);

    rst_n = 1'b1;
    step(5'b11111, 1'b0);
    check("first_sel", 8'(sel), 8'd0);
    check("first_gnt", 8'(gnt), 8'h01);

    // Rotation under continuous ack
    for (int i = 1; i <= 5; i++) begin
      step(5'b11111, 1'b1);
      check("rot_sel", 8'(sel), 8'(i % 5));
      check("rot_vld", 8'(vld), 8'd1);
    end

    // Skip and wrap: serve 2, then 00101 from ptr 3 wraps to 0, then 2
    step(5'b00100, 1'b1);
    check("skip_sel2", 8'(sel), 8'd2);
    step(5'b00101, 1'b1);
    check("wrap_sel0", 8'(sel), 8'd0);
    step(5'b00101, 1'b1);
    check("wrap_sel2", 8'(sel), 8'd2);

    // Hold: sel=1 frozen while requests change without ack
    step(5'b00010, 1'b1);
    check("hold_sel1", 8'(sel), 8'd1);
    for (int i = 0; i < 5; i++) begin
      step(5'b10000, 1'b0);
      check("hold_sel", 8'(sel), 8'd1);
      check("hold_gnt", 8'(gnt), 8'h02);
    end
    step(5'b10000, 1'b1);
    check("hold_next", 8'(sel), 8'd4);

    // Idle return and re-grant
    step(5'b01000, 1'b1);
    check("idle_sel3", 8'(sel), 8'd3);
    step(5'b00000, 1'b1);
    check("idle_vld", 8'(vld), 8'd0);
    check("idle_gnt", 8'(gnt), 8'd0);
    step(5'b00000, 1'b1);
    check("idle_ack_ign", 8'(vld), 8'd0);
    step(5'b01000, 1'b0);
    check("regrant_sel", 8'(sel), 8'd3);
    step(5'b00000, 1'b1);

    // Timeout behaviour (ptr is 4 here, so 00011 grants 0)
    step(5'b00011, 1'b0);
    check("to_grant", 8'(sel), 8'd0);
`ifdef MUX5_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      step(5'b00011, 1'b0);
      check("to_hold", 8'(sel), 8'd0);
      check("to_quiet", 8'(tout), 8'd0);
    end
    step(5'b00011, 1'b0);
    check("to_pulse", 8'(tout), 8'd1);
    check("to_sel1", 8'(sel), 8'd1);
    check("to_vld", 8'(vld), 8'd1);
    step(5'b00011, 1'b0);
    check("to_once", 8'(tout), 8'd0);
`else
    for (int i = 0; i < 20; i++) begin
      step(5'b00011, 1'b0);
      check("noto_sel", 8'(sel), 8'd0);
      check("noto_tout", 8'(tout), 8'd0);
    end
`endif
    step(5'b00000, 1'b1);

    // Reset while granted drops the grant without tout
    step(5'b00001, 1'b0);
    rst_n = 1'b0;
    step(5'b00001, 1'b0);
    check("rst_grant_vld", 8'(vld), 8'd0);
    check("rst_grant_tout", 8'(tout), 8'd0);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      step(5'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
